// File: rtl/full_seq.sv
// Sequencer for the `full` MAC: issues operand reads and MAC control pins row by row for a matrix-vector job.
// Latency: rd_en one cycle after start; row result (y_valid) len+RDLAT+MACLAT+1 cycles after its first read.
// No backpressure: start is ignored while busy; y must be consumed within one row period. Option: FULL_SEQ_CYCCNT_EN.
module full_seq #(
    parameter int AWIDTH = 10,
    parameter int LWIDTH = 10,
    parameter int RDLAT  = 1,
    parameter int MACLAT = 3
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [LWIDTH-1:0] len,
    input  logic [LWIDTH-1:0] rows,
    input  logic [AWIDTH-1:0] x_base,
    input  logic [AWIDTH-1:0] w_base,
    output logic              rd_en,
    output logic [AWIDTH-1:0] x_addr,
    output logic [AWIDTH-1:0] w_addr,
    output logic              mac_reset,
    output logic              mac_accum_we,
    output logic              mac_out_en,
    output logic              y_valid,
    output logic [LWIDTH-1:0] y_row,
    output logic              busy,
    output logic              done
`ifdef FULL_SEQ_CYCCNT_EN
    ,
    output logic [31:0]       cyc_cnt
`endif
);

    localparam int D = RDLAT + MACLAT;
    localparam logic [D-1:0] PIPE_ONE  = 1;
    // Every pipe stage except the last, which drives accum_we directly.
    localparam logic [D-1:0] HEAD_MASK = {D{1'b1}} >> 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    state_t            state, state_nx;
    logic [LWIDTH-1:0] len_q, rows_q, k_q, row_q, y_row_q;
    logic [AWIDTH-1:0] x_base_q, w_row_q;
    logic [D-1:0]      pipe;
    logic              busy_q, done_q, y_valid_q;

    logic accept, job_ok, last_k, last_row, head_busy, done_nx;

    assign accept    = (state == IDLE) && start && !busy_q;
    assign job_ok    = (len != '0) && (rows != '0);
    assign last_k    = (k_q == len_q - LWIDTH'(1));
    assign last_row  = (row_q == rows_q - LWIDTH'(1));
    assign head_busy = |(pipe & HEAD_MASK);
    assign done_nx   = ((state == EMIT) && last_row) || (accept && !job_ok);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept && job_ok) state_nx = ISSUE;
            ISSUE: if (last_k)           state_nx = WAIT;
            WAIT:  if (!head_busy)       state_nx = EMIT;
            EMIT:  state_nx = last_row ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en        = (state == ISSUE);
        mac_reset    = (state == ISSUE) && (k_q == '0);
        mac_out_en   = (state == EMIT);
        mac_accum_we = pipe[D-1];
        x_addr       = '0;
        w_addr       = '0;
        if (state == ISSUE) begin
            x_addr = x_base_q + AWIDTH'(k_q);
            w_addr = w_row_q + AWIDTH'(k_q);
        end
        y_valid = y_valid_q;
        y_row   = y_row_q;
        busy    = busy_q;
        done    = done_q;
    end

    // w_row_q tracks w_base + row*len by accumulation, so no multiplier is needed.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            len_q     <= '0;
            rows_q    <= '0;
            x_base_q  <= '0;
            w_row_q   <= '0;
            k_q       <= '0;
            row_q     <= '0;
            y_row_q   <= '0;
            pipe      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            pipe      <= (pipe << 1) | (rd_en ? PIPE_ONE : '0);
            busy_q    <= (state_nx != IDLE) || done_nx;
            done_q    <= done_nx;
            y_valid_q <= (state == EMIT);
            if (accept) begin
                len_q    <= len;
                rows_q   <= rows;
                x_base_q <= x_base;
                w_row_q  <= w_base;
                k_q      <= '0;
                row_q    <= '0;
            end
            if ((state == ISSUE) && !last_k) k_q <= k_q + LWIDTH'(1);
            if (state == EMIT) begin
                k_q     <= '0;
                y_row_q <= row_q;
                if (!last_row) begin
                    row_q   <= row_q + LWIDTH'(1);
                    w_row_q <= w_row_q + AWIDTH'(len_q);
                end
            end
        end
    end

`ifdef FULL_SEQ_CYCCNT_EN
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)       cyc_cnt <= '0;
        else if (accept) cyc_cnt <= '0;
        else if (busy_q) cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

endmodule
